// File: rtl/ac_tdm_core.sv
// ac_tdm_core: serial audio link core (I2S, left-justified, TDM) with
// run/drain control, DAC underrun flag and mute, in the audio clock domain.
// Ports:
//   clk, reset            audio master clock, synchronous active-high reset
//   enable, mute          run request; mute sampled at each frame start
//   clrFlags              clears the sticky underrun flag
//   audBclk/audLrck       bit clock and frame/word select to the codec
//   audAdcData/audDacData serial ADC input, serial DAC output
//   adcData/adcValid      received frame (ch k at [k*DATA_WDT +: DATA_WDT])
//   dacData/dacValid      frame to transmit, same packing
//   dacRdy                one-cycle pulse when dacData is taken
//   underrun, busy        sticky missing-DAC-frame flag, state != IDLE
module ac_tdm_core #(
    parameter int    CH_NUM   = 2,
    parameter int    DATA_WDT = 24,
    parameter int    SLOT_WDT = 32,
    parameter int    BCLK_DIV = 4,
    parameter string MODE     = "I2S"
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         mute,
    input  logic                         clrFlags,
    output logic                         audBclk,
    output logic                         audLrck,
    input  logic                         audAdcData,
    output logic                         audDacData,
    output logic [CH_NUM*DATA_WDT-1:0]   adcData,
    output logic                         adcValid,
    input  logic [CH_NUM*DATA_WDT-1:0]   dacData,
    input  logic                         dacValid,
    output logic                         dacRdy,
    output logic                         underrun,
    output logic                         busy
);

    localparam int  FB     = CH_NUM * SLOT_WDT;
    localparam int  TW     = CH_NUM * DATA_WDT;
    localparam int  HALF   = BCLK_DIV / 2;
    localparam int  CW     = $clog2(FB);
    localparam int  DCW    = $clog2(BCLK_DIV);
    localparam int  IW     = $clog2(TW);
    localparam bit  IS_I2S = (MODE == "I2S");
    localparam bit  IS_TDM = (MODE == "TDM");
    // I2S places each MSB one bclk after the word-select edge.
    localparam int  OFFS   = IS_I2S ? 1 : 0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [DCW-1:0]   div_q, div_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [TW-1:0]    tx_q, tx_ld, tx_src;
    logic [TW-1:0]    rx_q, rx_n;
    logic [TW-1:0]    adc_q;
    logic             bclk_q, lrck_q, dac_q, adcv_q, rdy_q, unr_q, busy_q;
    logic             frame_end, run_d, fall_d, start_d, rise_q, last_q;
    logic             lrck_n, tx_bit;
    logic [IW:0]      tmap, rmap;

    // Map a frame bit position to {is_data, flat sample bit index}.
    function automatic logic [IW:0] map_bit(input logic [CW-1:0] bc);
        int p;
        int s;
        int j;
        p = (int'(bc) + FB - OFFS) % FB;
        s = p / SLOT_WDT;
        j = p % SLOT_WDT;
        if (j < DATA_WDT)
            map_bit = {1'b1, IW'(s * DATA_WDT + DATA_WDT - 1 - j)};
        else
            map_bit = '0;
    endfunction

    assign frame_end = (div_q == DCW'(BCLK_DIV - 1)) && (bit_q == CW'(FB - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (enable) state_d = RUN;
            end
            default: begin
                if (!enable && frame_end) begin
                    state_d = IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    state_d = enable ? RUN : DRAIN;
                    if (div_q == DCW'(BCLK_DIV - 1)) begin
                        div_d = '0;
                        bit_d = (bit_q == CW'(FB - 1)) ? '0 : bit_q + 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Outputs are registered from next-state counters so they line up
    // with the counter phase of the cycle in which they are visible.
    assign run_d   = (state_d != IDLE);
    assign fall_d  = run_d && (div_d == '0);
    assign start_d = fall_d && (bit_d == '0);
    assign rise_q  = (state_q != IDLE) && (div_q == DCW'(HALF));
    assign last_q  = rise_q && (bit_q == CW'(FB - 1));

    assign tx_ld  = (dacValid && !mute) ? dacData : '0;
    assign tx_src = start_d ? tx_ld : tx_q;
    assign tmap   = map_bit(bit_d);
    assign rmap   = map_bit(bit_q);
    assign tx_bit = tmap[IW] ? tx_src[tmap[IW-1:0]] : 1'b0;

    always_comb begin
        rx_n = rx_q;
        if (rise_q && rmap[IW]) rx_n[rmap[IW-1:0]] = audAdcData;
    end

    always_comb begin
        if (IS_TDM)
            lrck_n = (bit_d == '0);
        else if (IS_I2S)
            lrck_n = (bit_d >= CW'(SLOT_WDT));
        else
            lrck_n = (bit_d < CW'(SLOT_WDT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            adc_q   <= '0;
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            dac_q   <= 1'b0;
            adcv_q  <= 1'b0;
            rdy_q   <= 1'b0;
            unr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            rx_q    <= rx_n;
            bclk_q  <= run_d && (div_d >= DCW'(HALF));
            rdy_q   <= start_d;
            busy_q  <= run_d;
            adcv_q  <= last_q;
            if (last_q) adc_q <= rx_n;
            if (start_d) tx_q <= tx_ld;
            if (!run_d) begin
                lrck_q <= 1'b0;
                dac_q  <= 1'b0;
            end else if (fall_d) begin
                lrck_q <= lrck_n;
                dac_q  <= tx_bit;
            end
            // A new underrun wins over a coincident clear.
            unr_q <= (start_d && !dacValid) || (unr_q && !clrFlags);
        end
    end

    assign audBclk    = bclk_q;
    assign audLrck    = lrck_q;
    assign audDacData = dac_q;
    assign adcData    = adc_q;
    assign adcValid   = adcv_q;
    assign dacRdy     = rdy_q;
    assign underrun   = unr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ac_tdm_core.sv
// tb_ac_tdm_core: directed bench for ac_tdm_core in I2S (loopback, mute,
// drain, reset), TDM 8x16 and left-justified (BCLK_DIV=2, underrun) modes.
module tb_ac_tdm_core;

    localparam logic [47:0] EXP = {24'h123456, 24'hABCDEF};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, mute, clrFlags;

    logic         i_en, i_dv;
    logic [47:0]  i_dd, i_adc;
    logic         i_bclk, i_lrck, i_dac, i_adcv, i_rdy, i_unr, i_busy;

    logic         t_en, t_dv;
    logic [127:0] t_dd, t_adc;
    logic         t_bclk, t_lrck, t_dac, t_adcv, t_rdy, t_unr, t_busy;

    logic         l_en, l_dv;
    logic [47:0]  l_dd, l_adc;
    logic         l_bclk, l_lrck, l_dac, l_adcv, l_rdy, l_unr, l_busy;

    int n_vec, n_err;
    int av_n, rdy_n, rdy_last, rdy_first, busy_lo, lr_n, ones1, ones2;
    int av_t[8];
    logic [47:0] av_d[8];
    logic [15:0] sh;

    ac_tdm_core #(.CH_NUM(2), .DATA_WDT(24), .SLOT_WDT(32),
                  .BCLK_DIV(4), .MODE("I2S")) u_i2s (
        .clk(clk), .reset(reset), .enable(i_en), .mute(mute),
        .clrFlags(clrFlags), .audBclk(i_bclk), .audLrck(i_lrck),
        .audAdcData(i_dac), .audDacData(i_dac), .adcData(i_adc),
        .adcValid(i_adcv), .dacData(i_dd), .dacValid(i_dv),
        .dacRdy(i_rdy), .underrun(i_unr), .busy(i_busy)
    );

    ac_tdm_core #(.CH_NUM(8), .DATA_WDT(16), .SLOT_WDT(16),
                  .BCLK_DIV(4), .MODE("TDM")) u_tdm (
        .clk(clk), .reset(reset), .enable(t_en), .mute(mute),
        .clrFlags(clrFlags), .audBclk(t_bclk), .audLrck(t_lrck),
        .audAdcData(t_dac), .audDacData(t_dac), .adcData(t_adc),
        .adcValid(t_adcv), .dacData(t_dd), .dacValid(t_dv),
        .dacRdy(t_rdy), .underrun(t_unr), .busy(t_busy)
    );

    ac_tdm_core #(.CH_NUM(2), .DATA_WDT(24), .SLOT_WDT(32),
                  .BCLK_DIV(2), .MODE("LEFT-JUSTIFIED")) u_lj (
        .clk(clk), .reset(reset), .enable(l_en), .mute(mute),
        .clrFlags(clrFlags), .audBclk(l_bclk), .audLrck(l_lrck),
        .audAdcData(l_dac), .audDacData(l_dac), .adcData(l_adc),
        .adcValid(l_adcv), .dacData(l_dd), .dacValid(l_dv),
        .dacRdy(l_rdy), .underrun(l_unr), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        mute = 1'b0;
        clrFlags = 1'b0;
        i_en = 1'b0; i_dv = 1'b1; i_dd = EXP;
        t_en = 1'b0; t_dv = 1'b1; t_dd = '0;
        l_en = 1'b0; l_dv = 1'b0; l_dd = EXP;
        for (int k = 0; k < 8; k++) t_dd[k*16 +: 16] = 16'h1000 + 16'(k);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_out", 128'({i_bclk, i_lrck, i_dac, i_adcv, i_rdy, i_unr, i_busy}), 128'(0));
        chk("rst_adc", 128'(i_adc), 128'(0));

        // I2S loopback, mute, drain
        i_en = 1'b1;
        tick();
        chk("i2s_rdy0", 128'(i_rdy), 128'(1));
        chk("i2s_busy0", 128'(i_busy), 128'(1));
        chk("i2s_bclk0", 128'(i_bclk), 128'(0));
        chk("i2s_lrck0", 128'(i_lrck), 128'(0));
        av_n = 0; rdy_n = 0; rdy_last = -1;
        for (int k = 0; k < 8; k++) begin
            av_t[k] = -1;
            av_d[k] = '1;
        end
        for (int t = 1; t <= 1800; t++) begin
            tick();
            if (i_adcv) begin
                if (av_n < 8) begin
                    av_t[av_n] = t;
                    av_d[av_n] = i_adc;
                end
                av_n++;
            end
            if (i_rdy) begin
                rdy_n++;
                rdy_last = t;
            end
            if (t == 1) chk("i2s_bclk_lo", 128'(i_bclk), 128'(0));
            if (t == 2) chk("i2s_bclk_hi", 128'(i_bclk), 128'(1));
            if (t == 128) chk("i2s_lrck_r", 128'(i_lrck), 128'(1));
            if (t == 1535) chk("drain_busy", 128'(i_busy), 128'(1));
            if (t == 1536) chk("drain_idle", 128'(i_busy), 128'(0));
            if (t == 600) mute = 1'b1;
            if (t == 900) mute = 1'b0;
            if (t == 1320) i_en = 1'b0;
        end
        chk("i2s_av_n", 128'(av_n), 128'(6));
        chk("i2s_rdy_n", 128'(rdy_n), 128'(5));
        chk("i2s_rdy_last", 128'(rdy_last), 128'(1280));
        chk("i2s_av_t0", 128'(av_t[0]), 128'(255));
        chk("i2s_av_t1", 128'(av_t[1]), 128'(511));
        chk("i2s_av_t5", 128'(av_t[5]), 128'(1535));
        chk("i2s_loop1", 128'(av_d[1]), 128'(EXP));
        chk("i2s_loop2", 128'(av_d[2]), 128'(EXP));
        chk("mute_zero", 128'(av_d[3]), 128'(0));
        chk("mute_off", 128'(av_d[4]), 128'(EXP));
        chk("drain_av", 128'(av_d[5]), 128'(EXP));
        chk("i2s_unr", 128'(i_unr), 128'(0));
        chk("idle_bclk", 128'(i_bclk), 128'(0));

        // re-enable in DRAIN, then reset mid-frame
        i_en = 1'b1;
        tick();
        chk("re_rdy0", 128'(i_rdy), 128'(1));
        busy_lo = 0; rdy_n = 0; rdy_first = -1; av_n = 0;
        for (int t = 1; t <= 1000; t++) begin
            tick();
            if (t <= 672 && !i_busy) busy_lo++;
            if (i_rdy) begin
                rdy_n++;
                if (rdy_first < 0) rdy_first = t;
            end
            if (t > 672 && i_adcv) av_n++;
            if (t == 673) begin
                chk("rst_mid_out", 128'({i_bclk, i_lrck, i_dac, i_adcv, i_rdy, i_unr, i_busy}), 128'(0));
                chk("rst_mid_adc", 128'(i_adc), 128'(0));
                reset = 1'b0;
            end
            if (t == 40) i_en = 1'b0;
            if (t == 100) i_en = 1'b1;
            if (t == 672) begin
                reset = 1'b1;
                i_en = 1'b0;
            end
        end
        chk("re_busy_gap", 128'(busy_lo), 128'(0));
        chk("re_rdy_first", 128'(rdy_first), 128'(256));
        chk("re_rdy_n", 128'(rdy_n), 128'(2));
        chk("rst_no_av", 128'(av_n), 128'(0));

        i_en = 1'b1;
        tick();
        chk("restart_rdy", 128'(i_rdy), 128'(1));
        av_t[0] = -1;
        av_d[0] = '1;
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (i_adcv && av_t[0] < 0) begin
                av_t[0] = t;
                av_d[0] = i_adc;
            end
        end
        chk("restart_av_t", 128'(av_t[0]), 128'(255));
        chk("restart_adc", 128'(av_d[0]), 128'(EXP));
        i_en = 1'b0;
        for (int t = 0; t < 300; t++) tick();

        // TDM 8 x 16
        t_en = 1'b1;
        tick();
        chk("tdm_rdy0", 128'(t_rdy), 128'(1));
        chk("tdm_lrck0", 128'(t_lrck), 128'(1));
        lr_n = 0; sh = '0; rdy_first = -1;
        for (int t = 1; t <= 1100; t++) begin
            tick();
            if (t >= 512 && t < 1024 && t_lrck) lr_n++;
            if (t >= 834 && t < 898 && ((t - 834) % 4) == 0) sh = {sh[14:0], t_dac};
            if (t_rdy && rdy_first < 0) rdy_first = t;
            if (t == 1023) begin
                chk("tdm_av", 128'(t_adcv), 128'(1));
                chk("tdm_adc", t_adc, t_dd);
            end
        end
        chk("tdm_lrck_w", 128'(lr_n), 128'(4));
        chk("tdm_slot5", 128'(sh), 128'(16'h1005));
        chk("tdm_period", 128'(rdy_first), 128'(512));
        t_en = 1'b0;
        for (int t = 0; t < 600; t++) tick();

        // left-justified, BCLK_DIV=2, underrun
        l_en = 1'b1;
        tick();
        chk("lj_rdy0", 128'(l_rdy), 128'(1));
        chk("lj_unr0", 128'(l_unr), 128'(1));
        chk("lj_lrck0", 128'(l_lrck), 128'(1));
        chk("lj_bclk0", 128'(l_bclk), 128'(0));
        ones1 = 0; ones2 = 0;
        for (int t = 1; t <= 400; t++) begin
            tick();
            if (t == 1) chk("lj_bclk1", 128'(l_bclk), 128'(1));
            if (t == 2) chk("lj_bclk2", 128'(l_bclk), 128'(0));
            if (t == 64) chk("lj_lrck_r", 128'(l_lrck), 128'(0));
            if (l_bclk && l_dac) begin
                if (t < 128) ones1++;
                else if (t < 256) ones2++;
            end
            if (t == 128) begin
                chk("lj_av0", 128'(l_adcv), 128'(1));
                chk("lj_adc0", 128'(l_adc), 128'(0));
            end
            if (t == 256) begin
                chk("lj_av1", 128'(l_adcv), 128'(1));
                chk("lj_adc1", 128'(l_adc), 128'(EXP));
            end
            if (t == 100) l_dv = 1'b1;
            if (t == 200) begin
                chk("lj_unr_sticky", 128'(l_unr), 128'(1));
                clrFlags = 1'b1;
            end
            if (t == 201) begin
                chk("lj_unr_clr", 128'(l_unr), 128'(0));
                clrFlags = 1'b0;
            end
            if (t == 300) l_dv = 1'b0;
            if (t == 383) clrFlags = 1'b1;
            if (t == 384) begin
                chk("lj_set_wins", 128'(l_unr), 128'(1));
                clrFlags = 1'b0;
            end
            if (t == 390) chk("lj_unr_hold", 128'(l_unr), 128'(1));
        end
        chk("lj_zero_frame", 128'(ones1), 128'(0));
        chk("lj_data_ones", 128'(ones2), 128'(26));
        l_en = 1'b0;
        for (int t = 0; t < 200; t++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
